// File: rtl/forbid_seq_monitor.sv
// forbid_seq_monitor
// Watches for the forbidden pattern "p, then q exactly DELAY cycles later".
// A p-history shift register remembers enabled p samples. A match raises a
// one-cycle viol pulse, sets a sticky err flag, bumps a saturating counter
// and, on the first match only, records a free-running cycle timestamp.
// A synchronous clr wipes all status and the p history. If clr arrives on
// the same edge as a match, clr wins and the match is dropped.

module forbid_seq_monitor #(
    parameter int DELAY = 1,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             p,
    input  logic             q,
    input  logic             clr,
    output logic             viol,
    output logic             err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [TS_W-1:0]  first_ts,
    output logic             ts_valid
);

    // A DELAY outside 1..15 has no meaningful history depth, so reject it
    // when the design is elaborated.
    generate
        if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
            $error("forbid_seq_monitor: DELAY must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // p_hist[i] holds the enabled p sample taken i+1 edges ago.
    logic [DELAY-1:0] p_hist;
    logic [TS_W-1:0]  ts;
    logic             p_sample;
    logic             hit;
    logic             detect;

    // A p sample taken while en is low never counts as an antecedent.
    assign p_sample = p & en;

    // A hit needs en and q at this edge, plus p from DELAY edges ago.
    assign hit      = en & q & p_hist[DELAY-1];

    // clr takes priority, so a hit at a clearing edge is discarded.
    assign detect   = hit & ~clr;

    generate
        if (DELAY == 1) begin : g_hist_one
            // Single-stage history: remember the latest enabled p sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_hist <= '0;
                end else if (clr) begin
                    p_hist <= '0;
                end else begin
                    p_hist <= p_sample;
                end
            end
        end else begin : g_hist_multi
            // Multi-stage history: shift the enabled p sample in at bit 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_hist <= '0;
                end else if (clr) begin
                    p_hist <= '0;
                end else begin
                    p_hist <= {p_hist[DELAY-2:0], p_sample};
                end
            end
        end
    endgenerate

    // Free-running cycle counter. It wraps naturally and ignores en and clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // viol is a registered pulse, one cycle after the edge that matched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol <= 1'b0;
        end else begin
            viol <= detect;
        end
    end

    // err is sticky: set by any match, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (detect) begin
            err <= 1'b1;
        end
    end

    // The violation counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt <= '0;
        end else if (clr) begin
            viol_cnt <= '0;
        end else if (detect && viol_cnt != CNT_MAX) begin
            viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end

    // Record the timestamp of the matching edge, but only the first match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_ts <= '0;
            ts_valid <= 1'b0;
        end else if (clr) begin
            first_ts <= '0;
            ts_valid <= 1'b0;
        end else if (detect && !ts_valid) begin
            first_ts <= ts;
            ts_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_forbid_seq_monitor.sv
// Testbench for forbid_seq_monitor.
// Three instances share one stimulus: DELAY=1 with an 8-bit counter,
// DELAY=3, and DELAY=1 with a 2-bit counter. A table of vectors exercises
// the DELAY=1 instance. Hand-written sequences cover the DELAY=3 instance,
// counter saturation, and an asynchronous reset in mid-sequence.

module tb_forbid_seq_monitor;

    logic clk;
    logic rst_n;
    logic en;
    logic p;
    logic q;
    logic clr;

    logic        viol1, err1, valid1;
    logic [7:0]  cnt1;
    logic [15:0] fts1;

    logic        viol3, err3, valid3;
    logic [7:0]  cnt3;
    logic [15:0] fts3;

    logic        violS, errS, validS;
    logic [1:0]  cntS;
    logic [15:0] ftsS;

    int checks;
    int errors;

    typedef struct {
        logic en;
        logic p;
        logic q;
        logic clr;
        logic viol;
        logic err;
        int   cnt;
        int   fts;
        logic valid;
    } vec_t;

    vec_t vecs[$];

    forbid_seq_monitor #(.DELAY(1), .CNT_W(8), .TS_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p), .q(q), .clr(clr),
        .viol(viol1), .err(err1), .viol_cnt(cnt1), .first_ts(fts1), .ts_valid(valid1)
    );

    forbid_seq_monitor #(.DELAY(3), .CNT_W(8), .TS_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p), .q(q), .clr(clr),
        .viol(viol3), .err(err3), .viol_cnt(cnt3), .first_ts(fts3), .ts_valid(valid3)
    );

    forbid_seq_monitor #(.DELAY(1), .CNT_W(2), .TS_W(16)) us (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p), .q(q), .clr(clr),
        .viol(violS), .err(errS), .viol_cnt(cntS), .first_ts(ftsS), .ts_valid(validS)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the inputs, wait for the active edge, then settle 1 ns past it.
    task automatic applyStimulus(input logic e, input logic pv, input logic qv, input logic c);
        en  = e;
        p   = pv;
        q   = qv;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Hold reset for two edges, then release it 1 ns after an edge. The next
    // edge is edge 0, where the cycle counter reads 0.
    task automatic resetDut();
        rst_n = 1'b0;
        en = 1'b0; p = 1'b0; q = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic addVec(input logic e, input logic pv, input logic qv, input logic c,
                          input logic v, input logic er, input int cn, input int ft,
                          input logic va);
        vec_t t;
        t.en = e; t.p = pv; t.q = qv; t.clr = c;
        t.viol = v; t.err = er; t.cnt = cn; t.fts = ft; t.valid = va;
        vecs.push_back(t);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en = 1'b0; p = 1'b0; q = 1'b0; clr = 1'b0;

        // Vectors for the DELAY=1 instance. Row i is applied at edge i, and
        // the expected outputs are those registered at that edge.
        //      en p  q  clr  viol err cnt fts valid
        addVec(1, 0, 0, 0,   0,  0,  0,  0,  0); // e0
        addVec(1, 0, 0, 0,   0,  0,  0,  0,  0); // e1
        addVec(1, 0, 0, 0,   0,  0,  0,  0,  0); // e2
        addVec(1, 1, 0, 0,   0,  0,  0,  0,  0); // e3  p
        addVec(1, 0, 1, 0,   1,  1,  1,  4,  1); // e4  q -> violation at ts 4
        addVec(1, 0, 0, 0,   0,  1,  1,  4,  1); // e5
        addVec(1, 1, 1, 0,   0,  1,  1,  4,  1); // e6  overlap: p and q held
        addVec(1, 1, 1, 0,   1,  1,  2,  4,  1); // e7
        addVec(1, 1, 1, 0,   1,  1,  3,  4,  1); // e8
        addVec(1, 1, 1, 0,   1,  1,  4,  4,  1); // e9
        addVec(1, 1, 1, 0,   1,  1,  5,  4,  1); // e10
        addVec(1, 0, 0, 0,   0,  1,  5,  4,  1); // e11
        addVec(0, 1, 0, 0,   0,  1,  5,  4,  1); // e12 p while disabled
        addVec(1, 0, 1, 0,   0,  1,  5,  4,  1); // e13 q: no match
        addVec(1, 1, 0, 0,   0,  1,  5,  4,  1); // e14 p
        addVec(0, 0, 1, 0,   0,  1,  5,  4,  1); // e15 q while disabled
        addVec(1, 0, 1, 0,   0,  1,  5,  4,  1); // e16
        addVec(1, 1, 0, 0,   0,  1,  5,  4,  1); // e17 p
        addVec(1, 1, 1, 1,   0,  0,  0,  0,  0); // e18 match during clr: dropped
        addVec(1, 0, 1, 0,   0,  0,  0,  0,  0); // e19 p from e18 discarded
        addVec(1, 1, 0, 1,   0,  0,  0,  0,  0); // e20 clr held
        addVec(1, 1, 1, 1,   0,  0,  0,  0,  0); // e21
        addVec(1, 0, 1, 0,   0,  0,  0,  0,  0); // e22 nothing from clr window
        addVec(1, 1, 0, 0,   0,  0,  0,  0,  0); // e23 p
        addVec(1, 0, 1, 0,   1,  1,  1, 24,  1); // e24 first_ts recaptured
        addVec(1, 0, 0, 0,   0,  1,  1, 24,  1); // e25

        // Check the state held during reset, before any clock edge matters.
        #2;
        checkOutput("reset.viol", viol1, 0);
        checkOutput("reset.err", err1, 0);
        checkOutput("reset.cnt", cnt1, 0);
        checkOutput("reset.fts", fts1, 0);
        checkOutput("reset.valid", valid1, 0);

        resetDut();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].p, vecs[i].q, vecs[i].clr);
            checkOutput($sformatf("vec%0d.viol", i), viol1, vecs[i].viol);
            checkOutput($sformatf("vec%0d.err", i), err1, vecs[i].err);
            checkOutput($sformatf("vec%0d.cnt", i), cnt1, vecs[i].cnt);
            checkOutput($sformatf("vec%0d.fts", i), fts1, vecs[i].fts);
            checkOutput($sformatf("vec%0d.valid", i), valid1, vecs[i].valid);
        end

        // DELAY=3: p only at edge 5. A q at edge 7 is too early; q at edge 8 matches.
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);   // e5
        applyStimulus(1, 0, 0, 0);   // e6
        applyStimulus(1, 0, 1, 0);   // e7
        checkOutput("d3.e7.viol", viol3, 0);
        checkOutput("d3.e7.cnt", cnt3, 0);
        applyStimulus(1, 0, 1, 0);   // e8
        checkOutput("d3.e8.viol", viol3, 1);
        checkOutput("d3.e8.cnt", cnt3, 1);
        checkOutput("d3.e8.fts", fts3, 8);
        applyStimulus(1, 0, 0, 0);   // e9
        checkOutput("d3.e9.viol", viol3, 0);
        checkOutput("d3.e9.err", err3, 1);

        // Saturation: 2-bit counter, six violations at edges 2..7.
        resetDut();
        applyStimulus(1, 0, 0, 0);   // e0
        applyStimulus(1, 1, 0, 0);   // e1
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(1, (i <= 6) ? 1'b1 : 1'b0, 1, 0);
            checkOutput($sformatf("sat.e%0d.viol", i), violS, 1);
            checkOutput($sformatf("sat.e%0d.cnt", i), cntS, (i - 1 > 3) ? 3 : i - 1);
        end
        checkOutput("sat.err", errS, 1);
        checkOutput("sat.fts", ftsS, 2);
        checkOutput("sat.valid", validS, 1);

        // Reset mid-operation: p at an edge, reset pulsed, then q at the next edge.
        applyStimulus(1, 1, 0, 0);
        checkOutput("rst.pre.err", err1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async.err", err1, 0);
        checkOutput("rst.async.cnt", cnt1, 0);
        checkOutput("rst.async.valid", valid1, 0);
        rst_n = 1'b1;
        applyStimulus(1, 0, 1, 0);
        checkOutput("rst.post.viol", viol1, 0);
        checkOutput("rst.post.err", err1, 0);
        checkOutput("rst.post.cnt", cnt1, 0);
        checkOutput("rst.post.fts", fts1, 0);
        checkOutput("rst.post.valid", valid1, 0);
        checkOutput("rst.post.viol_sat", violS, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forbid_seq_monitor.md
FORBID_SEQ_MONITOR -- requirements
Module: forbid_seq_monitor

Interface
REQ-001 SHALL have parameter DELAY, default 1, cycle distance between p and the forbidden q (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, width of the violation counter.
REQ-003 SHALL have parameter TS_W, default 16, width of the cycle timestamp.
REQ-004 SHALL have port clk  input  1  single clock; all sampling on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  monitor enable; low suppresses detection.
REQ-007 SHALL have port p  input  1  antecedent signal under observation.
REQ-008 SHALL have port q  input  1  consequent signal; q high DELAY cycles after p is forbidden.
REQ-009 SHALL have port clr  input  1  synchronous clear of all status.
REQ-010 SHALL have port viol  output  1  one-cycle violation pulse.
REQ-011 SHALL have port err  output  1  sticky error flag.
REQ-012 SHALL have port viol_cnt  output  CNT_W  saturating violation count.
REQ-013 SHALL have port first_ts  output  TS_W  timestamp of first violation.
REQ-014 SHALL have port ts_valid  output  1  first_ts holds a captured value.

Function
REQ-015 SHALL keep a DELAY-deep p-history shift register; each posedge shifts in (p & en).
REQ-016 SHALL detect a violation at posedge k when en=1, q=1 and the p sample from edge k-DELAY (history tap DELAY-1) is 1.
REQ-017 SHALL register viol: viol high in the cycle after edge k, exactly 1 cycle latency; low otherwise.
REQ-018 SHALL detect overlapping occurrences independently: p held high and q held high yields one violation per edge.
REQ-019 SHALL NOT count a violation whose p sample was taken while en=0, nor one at an edge where en=0.
REQ-020 SHALL keep a free-running TS_W cycle counter ts, incremented every posedge, wrapping from all-ones to 0, unaffected by en and clr.
REQ-021 SHALL set err on the first detected violation and hold it until clr or reset.
REQ-022 SHALL increment viol_cnt by 1 per violation and saturate at 2^CNT_W-1 (no wrap).
REQ-023 SHALL capture ts value of edge k into first_ts and set ts_valid only when ts_valid=0; later violations leave first_ts unchanged.
REQ-024 SHALL, on clr=1 at an edge, clear err, viol_cnt, first_ts, ts_valid, viol and the p history; clr has priority over a violation detected at the same edge (discarded, not counted).
REQ-025 SHALL, with clr held high, detect nothing; detection resumes using only p samples taken after clr deasserts.
REQ-026 SHALL treat DELAY outside 1..15 as an elaboration error.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force viol=0, err=0, viol_cnt=0, first_ts=0, ts_valid=0, ts=0 and p history to all zeros.
REQ-028 SHALL, on reset assertion mid-sequence, discard any pending p history so no violation is reported from pre-reset p samples.
REQ-029 SHALL release synchronously usable on the first posedge after rst_n rises; ts counts 0 at that edge.

Verification
REQ-030 SHALL cover basic: DELAY=1, en=1, p=1 at edge 3, q=1 at edge 4 -> viol=1 during cycle after edge 4, viol_cnt=1, err=1, first_ts=4, ts_valid=1.
REQ-031 SHALL cover overlap: DELAY=1, p=1 and q=1 held edges 2..6 -> viol high for 4 consecutive cycles, viol_cnt=4, first_ts=3.
REQ-032 SHALL cover DELAY=3: p=1 at edge 5 only, q=1 at edge 7 -> no viol; q=1 at edge 8 -> viol, viol_cnt=1.
REQ-033 SHALL cover enable/clear: en=0 at p edge -> no viol; violation coincident with clr=1 -> viol_cnt=0, err=0, ts_valid=0 afterwards.
REQ-034 SHALL cover saturation: CNT_W=2, six violations -> viol_cnt=3, err=1, first_ts unchanged from first.
REQ-035 SHALL cover reset mid-operation: p=1, rst_n pulsed low between edges, q=1 next edge -> no viol, all outputs 0.
